regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 57 +++++
 rtl/regfile_mp.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address mux, zero check, optional bypass.
// Forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [(2**ADDR_W)*DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            data
);

  logic [DATA_W-1:0] sel;
  logic [DATA_W-1:0] nxt;
  logic              zero;
  logic              hit;

  always_comb begin
    sel = regs[int'(addr)*DATA_W +: DATA_W];
  end

  assign zero = (addr == '0);

`ifdef REGFILE_BYPASS_EN
  // wr_en already excludes address 0 and the clear sweep
  assign hit = wr_en && (wr_addr == addr);
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data};
  assign hit = 1'b0;
`endif

  always_comb begin
    nxt = sel;
    unique case (1'b1)
      zero:    nxt = '0;
      hit:     nxt = wr_data;
      default: nxt = sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data <= '0;
    end else begin
      data <= nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a post-reset zero sweep.
// Optional feature macro: REGFILE_BYPASS_EN (handled in regfile_rd_port).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         busy,
  output logic [(2**ADDR_W)*DATA_W-1:0] regs
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clearing;
  logic              wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (clr_ptr == LAST) state_nx = READY;
      READY: state_nx = READY;
      default: state_nx = CLEAR;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  assign clearing = (state == CLEAR);
  assign wr_en    = (state == READY) && we
                    && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr <= '0;
    end else if (clearing) begin
      clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // The array itself has no reset; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        mem[clr_ptr] <= '0;
      end else if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 1; i < DEPTH; i++) begin
      regs[i*DATA_W +: DATA_W] = mem[i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk     (clk),
      .rst     (rst),
      .clear   (clearing),
      .regs    (regs),
      .addr    (rd_addr[k*ADDR_W +: ADDR_W]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule
